// File: rtl/crack_scheduler.sv
// crack_scheduler: hands out 24-bit ARC4 candidate keys to a pool of crack cores in
// round-robin order, stops the search on the first reported match and presents the
// matching key with the same rdy/en/key/key_valid handshake as a single crack engine.
// Optional build macro CRACK_PROGRESS_EN adds the keys_tried progress counter output.
module crack_scheduler #(
    parameter int unsigned NUM_CORES = 2,
    parameter logic [23:0] KEY_FIRST = 24'h000000,
    parameter logic [23:0] KEY_LAST  = 24'hFFFFFF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    output logic                 rdy,
    output logic [23:0]          key,
    output logic                 key_valid,
    input  logic [NUM_CORES-1:0] core_req,
    output logic [NUM_CORES-1:0] core_gnt,
    output logic [23:0]          core_key,
    input  logic [NUM_CORES-1:0] core_done,
    input  logic [NUM_CORES-1:0] core_match,
    output logic                 core_abort
`ifdef CRACK_PROGRESS_EN
    ,
    output logic [23:0]          keys_tried
`endif
);

    localparam int unsigned PtrW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StAbort, StDone} state_e;

    state_e                 state_q, state_d;
    logic [23:0]            next_key_q, next_key_d;
    logic                   exhausted_q, exhausted_d;
    logic [NUM_CORES-1:0]   busy_q, busy_d;
    logic [23:0]            assigned_q [NUM_CORES];
    logic [23:0]            assigned_d [NUM_CORES];
    logic [PtrW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [NUM_CORES-1:0]   gnt_q, gnt_d;
    logic [23:0]            gnt_key_q, gnt_key_d;
    logic [23:0]            key_q, key_d;
    logic                   key_valid_q, key_valid_d;

    logic                   start;
    logic [NUM_CORES-1:0]   eligible;
    logic [NUM_CORES-1:0]   match_vec;
    logic [NUM_CORES-1:0]   pick_hi, pick_lo, gnt_oh;
    logic                   found_hi, found_lo, found_win;
    logic                   grant_ok, match_hit;
    logic [PtrW-1:0]        rr_next;
    logic [23:0]            win_key;

    assign start     = ((state_q == StIdle) || (state_q == StDone)) && en;
    assign eligible  = core_req & ~busy_q;
    assign match_vec = core_done & core_match & busy_q;

    // Round-robin pick (first eligible at or above the pointer, else lowest) and match winner.
    always_comb begin
        pick_hi   = '0;
        pick_lo   = '0;
        found_hi  = 1'b0;
        found_lo  = 1'b0;
        found_win = 1'b0;
        win_key   = '0;
        rr_next   = rr_ptr_q;
        for (int i = 0; i < int'(NUM_CORES); i++) begin
            if (!found_hi && eligible[i] && (i >= int'(rr_ptr_q))) begin
                pick_hi[i] = 1'b1;
                found_hi   = 1'b1;
            end
            if (!found_lo && eligible[i]) begin
                pick_lo[i] = 1'b1;
                found_lo   = 1'b1;
            end
            if (!found_win && match_vec[i]) begin
                win_key   = assigned_q[i];
                found_win = 1'b1;
            end
        end
        gnt_oh = found_hi ? pick_hi : pick_lo;
        for (int i = 0; i < int'(NUM_CORES); i++) begin
            if (gnt_oh[i]) begin
                rr_next = PtrW'((i + 1) % int'(NUM_CORES));
            end
        end
        grant_ok  = (state_q == StRun) && !exhausted_q && found_lo;
        match_hit = (state_q == StRun) && found_win;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: a match outranks exhaustion; exhaustion waits for all cores to drain.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle, StDone: begin
                if (en) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (match_hit) begin
                    state_d = StAbort;
                end else if (exhausted_q && (busy_q == '0)) begin
                    state_d = StDone;
                end
            end
            StAbort: state_d = StDone;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs.
    always_comb begin
        rdy        = (state_q == StIdle) || (state_q == StDone);
        core_abort = (state_q == StAbort);
        key        = key_q;
        key_valid  = key_valid_q;
        core_gnt   = gnt_q;
        core_key   = gnt_key_q;
    end

    // Datapath next-state: key dispatch, busy tracking and match capture.
    always_comb begin
        next_key_d  = next_key_q;
        exhausted_d = exhausted_q;
        busy_d      = busy_q;
        assigned_d  = assigned_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_d       = '0;
        gnt_key_d   = '0;
        key_d       = key_q;
        key_valid_d = key_valid_q;
        if (start) begin
            next_key_d  = KEY_FIRST;
            exhausted_d = 1'b0;
            busy_d      = '0;
            rr_ptr_d    = '0;
            key_d       = '0;
            key_valid_d = 1'b0;
        end else if (state_q == StRun) begin
            busy_d = busy_q & ~core_done;
            if (grant_ok) begin
                gnt_d     = gnt_oh;
                gnt_key_d = next_key_q;
                busy_d    = busy_d | gnt_oh;
                rr_ptr_d  = rr_next;
                for (int i = 0; i < int'(NUM_CORES); i++) begin
                    if (gnt_oh[i]) begin
                        assigned_d[i] = next_key_q;
                    end
                end
                // Hold at KEY_LAST rather than wrapping so the key space is covered once.
                if (next_key_q == KEY_LAST) begin
                    exhausted_d = 1'b1;
                end else begin
                    next_key_d = next_key_q + 24'd1;
                end
            end
            if (match_hit) begin
                key_d       = win_key;
                key_valid_d = 1'b1;
            end
        end else if (state_q == StAbort) begin
            busy_d = '0;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            next_key_q  <= KEY_FIRST;
            exhausted_q <= 1'b0;
            busy_q      <= '0;
            rr_ptr_q    <= '0;
            gnt_q       <= '0;
            gnt_key_q   <= '0;
            key_q       <= '0;
            key_valid_q <= 1'b0;
            for (int i = 0; i < int'(NUM_CORES); i++) begin
                assigned_q[i] <= '0;
            end
        end else begin
            next_key_q  <= next_key_d;
            exhausted_q <= exhausted_d;
            busy_q      <= busy_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_q       <= gnt_d;
            gnt_key_q   <= gnt_key_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            assigned_q  <= assigned_d;
        end
    end

`ifdef CRACK_PROGRESS_EN
    logic [23:0] tried_q, tried_d;
    logic [24:0] tried_sum;

    // Progress counter: completions from busy cores, saturating, cleared on a new search.
    always_comb begin
        tried_sum = {1'b0, tried_q};
        for (int i = 0; i < int'(NUM_CORES); i++) begin
            if ((state_q == StRun) && core_done[i] && busy_q[i]) begin
                tried_sum = tried_sum + 25'd1;
            end
        end
        tried_d = tried_sum[24] ? 24'hFFFFFF : tried_sum[23:0];
        if (start) begin
            tried_d = '0;
        end
    end

    // Progress counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tried_q <= '0;
        end else begin
            tried_q <= tried_d;
        end
    end

    assign keys_tried = tried_q;
`endif

endmodule

// File: tb/tb_crack_scheduler.sv
// Directed bench for crack_scheduler: three instances cover a 6-key sweep on two cores,
// a simultaneous double match, and a single-key range at the top of the key space on one core.
module tb_crack_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Instance A: two cores, keys 0..5.
    logic        en_a, rdy_a, key_valid_a, abort_a;
    logic [23:0] key_a, ckey_a;
    logic [1:0]  req_a, gnt_a, done_a, match_a;
    // Instance B: one core, single key 24'hFFFFFF.
    logic        en_b, rdy_b, key_valid_b, abort_b;
    logic [23:0] key_b, ckey_b;
    logic [0:0]  req_b, gnt_b, done_b, match_b;
    // Instance C: two cores, keys 8..15.
    logic        en_c, rdy_c, key_valid_c, abort_c;
    logic [23:0] key_c, ckey_c;
    logic [1:0]  req_c, gnt_c, done_c, match_c;
`ifdef CRACK_PROGRESS_EN
    logic [23:0] tried_a, tried_b, tried_c;
`endif

    int n_checks = 0;
    int n_err    = 0;

    crack_scheduler #(.NUM_CORES(2), .KEY_FIRST(24'h000000), .KEY_LAST(24'h000005)) u_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en_a),
        .rdy        (rdy_a),
        .key        (key_a),
        .key_valid  (key_valid_a),
        .core_req   (req_a),
        .core_gnt   (gnt_a),
        .core_key   (ckey_a),
        .core_done  (done_a),
        .core_match (match_a),
        .core_abort (abort_a)
`ifdef CRACK_PROGRESS_EN
        ,
        .keys_tried (tried_a)
`endif
    );

    crack_scheduler #(.NUM_CORES(1), .KEY_FIRST(24'hFFFFFF), .KEY_LAST(24'hFFFFFF)) u_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en_b),
        .rdy        (rdy_b),
        .key        (key_b),
        .key_valid  (key_valid_b),
        .core_req   (req_b),
        .core_gnt   (gnt_b),
        .core_key   (ckey_b),
        .core_done  (done_b),
        .core_match (match_b),
        .core_abort (abort_b)
`ifdef CRACK_PROGRESS_EN
        ,
        .keys_tried (tried_b)
`endif
    );

    crack_scheduler #(.NUM_CORES(2), .KEY_FIRST(24'h000008), .KEY_LAST(24'h00000F)) u_c (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en_c),
        .rdy        (rdy_c),
        .key        (key_c),
        .key_valid  (key_valid_c),
        .core_req   (req_c),
        .core_gnt   (gnt_c),
        .core_key   (ckey_c),
        .core_done  (done_c),
        .core_match (match_c),
        .core_abort (abort_c)
`ifdef CRACK_PROGRESS_EN
        ,
        .keys_tried (tried_c)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full search on instance A with two emulated cores that finish 3 cycles after a grant.
    task automatic run_a(input bit use_match, input logic [23:0] mkey, input int exp_grants,
                         input bit en_mid);
        int          cnt [2];
        logic [23:0] held [2];
        int          ngr;
        int          nab;
        int          cyc;
        int          abort_cyc;
        ngr = 0;
        nab = 0;
        cyc = 0;
        abort_cyc = -100;
        for (int i = 0; i < 2; i++) begin
            cnt[i]  = 0;
            held[i] = '0;
        end
        req_a   = 2'b11;
        done_a  = 2'b00;
        match_a = 2'b00;
        chk("a_start_rdy", 32'(rdy_a), 32'd1);
        en_a = 1'b1;
        tick();
        en_a = 1'b0;
        chk("a_run_rdy", 32'(rdy_a), 32'd0);
        chk("a_run_kv", 32'(key_valid_a), 32'd0);
        chk("a_run_key", 32'(key_a), 32'd0);
        while (!rdy_a && cyc < 200) begin
            if (gnt_a != 2'b00) begin
                chk("a_gnt_core", 32'(gnt_a), (ngr % 2 == 0) ? 32'd1 : 32'd2);
                chk("a_gnt_key", 32'(ckey_a), 32'(ngr));
                ngr++;
            end else begin
                chk("a_idle_core_key", 32'(ckey_a), 32'd0);
            end
            if (abort_a) begin
                nab++;
                abort_cyc = cyc;
            end
            done_a  = 2'b00;
            match_a = 2'b00;
            for (int i = 0; i < 2; i++) begin
                if (abort_a) begin
                    cnt[i] = 0;
                end else if (gnt_a[i]) begin
                    cnt[i]  = 3;
                    held[i] = ckey_a;
                end else if (cnt[i] > 0) begin
                    cnt[i]--;
                    if (cnt[i] == 0) begin
                        done_a[i]  = 1'b1;
                        match_a[i] = use_match && (held[i] == mkey);
                    end
                end
            end
            en_a = en_mid && (cyc == 4);
            tick();
            cyc++;
        end
        en_a    = 1'b0;
        done_a  = 2'b00;
        match_a = 2'b00;
        chk("a_end_rdy", 32'(rdy_a), 32'd1);
        chk("a_grants", 32'(ngr), 32'(exp_grants));
        chk("a_aborts", 32'(nab), 32'(use_match));
        chk("a_key", 32'(key_a), use_match ? 32'(mkey) : 32'd0);
        chk("a_kv", 32'(key_valid_a), 32'(use_match));
        chk("a_end_gnt", 32'(gnt_a), 32'd0);
        if (use_match) begin
            chk("a_rdy_after_abort", 32'(cyc - abort_cyc), 32'd1);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en_a = 1'b0; req_a = 2'b00; done_a = 2'b00; match_a = 2'b00;
        en_b = 1'b0; req_b = 1'b0;  done_b = 1'b0;  match_b = 1'b0;
        en_c = 1'b0; req_c = 2'b00; done_c = 2'b00; match_c = 2'b00;
        tick();
        tick();
        chk("rst_rdy", 32'(rdy_a), 32'd1);
        chk("rst_key", 32'(key_a), 32'd0);
        chk("rst_kv", 32'(key_valid_a), 32'd0);
        chk("rst_gnt", 32'(gnt_a), 32'd0);
        chk("rst_abort", 32'(abort_a), 32'd0);
        chk("rst_core_key", 32'(ckey_a), 32'd0);
        rst_n = 1'b1;
        req_a = 2'b11;
        tick();
        chk("idle_no_gnt", 32'(gnt_a), 32'd0);

        // Sweep 0..5 with no match, en pulsed mid-search.
        run_a(1'b0, 24'h0, 6, 1'b1);
`ifdef CRACK_PROGRESS_EN
        chk("a_keys_tried", 32'(tried_a), 32'd6);
`endif
        tick();
        chk("a_done_hold_rdy", 32'(rdy_a), 32'd1);
        chk("a_done_no_abort", 32'(abort_a), 32'd0);

        // Core 1 matches on key 3; key 4 is granted in the match cycle and then aborted.
        run_a(1'b1, 24'h000003, 5, 1'b0);
        tick();
        tick();
        chk("a_done_hold_key", 32'(key_a), 32'd3);
        chk("a_done_hold_kv", 32'(key_valid_a), 32'd1);

        // Simultaneous match on cores 0 and 1 holding keys 8 and 9.
        chk("c_rdy0", 32'(rdy_c), 32'd1);
        req_c = 2'b11;
        en_c = 1'b1;
        tick();
        en_c = 1'b0;
        tick();
        chk("c_gnt0", 32'(gnt_c), 32'd1);
        chk("c_key0", 32'(ckey_c), 32'h8);
        tick();
        chk("c_gnt1", 32'(gnt_c), 32'd2);
        chk("c_key1", 32'(ckey_c), 32'h9);
        done_c = 2'b11;
        match_c = 2'b11;
        tick();
        done_c = 2'b00;
        match_c = 2'b00;
        chk("c_abort", 32'(abort_c), 32'd1);
        chk("c_abort_rdy", 32'(rdy_c), 32'd0);
        chk("c_abort_gnt", 32'(gnt_c), 32'd0);
        tick();
        chk("c_done_abort", 32'(abort_c), 32'd0);
        chk("c_done_rdy", 32'(rdy_c), 32'd1);
        chk("c_key", 32'(key_c), 32'h8);
        chk("c_kv", 32'(key_valid_c), 32'd1);

        // Single key at the top of the key space on a one-core pool.
        req_b = 1'b1;
        en_b = 1'b1;
        tick();
        en_b = 1'b0;
        tick();
        chk("b_gnt", 32'(gnt_b), 32'd1);
        chk("b_key", 32'(ckey_b), 32'hFFFFFF);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("b_wait_gnt", 32'(gnt_b), 32'd0);
            chk("b_wait_rdy", 32'(rdy_b), 32'd0);
        end
        done_b = 1'b1;
        tick();
        done_b = 1'b0;
        chk("b_drain_rdy", 32'(rdy_b), 32'd0);
        chk("b_drain_abort", 32'(abort_b), 32'd0);
        tick();
        chk("b_no_wrap_gnt", 32'(gnt_b), 32'd0);
        chk("b_done_rdy", 32'(rdy_b), 32'd1);
        chk("b_done_kv", 32'(key_valid_b), 32'd0);
        chk("b_done_key", 32'(key_b), 32'd0);
        chk("b_done_abort", 32'(abort_b), 32'd0);

        // en in DONE clears the previous match; reset while both cores are busy.
        en_a = 1'b1;
        tick();
        en_a = 1'b0;
        chk("r_kv_cleared", 32'(key_valid_a), 32'd0);
        chk("r_rdy_low", 32'(rdy_a), 32'd0);
        tick();
        chk("r_gnt0", 32'(gnt_a), 32'd1);
        chk("r_key0", 32'(ckey_a), 32'd0);
        tick();
        chk("r_gnt1", 32'(gnt_a), 32'd2);
        chk("r_key1", 32'(ckey_a), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("r_rst_rdy", 32'(rdy_a), 32'd1);
        chk("r_rst_kv", 32'(key_valid_a), 32'd0);
        chk("r_rst_gnt", 32'(gnt_a), 32'd0);
        chk("r_rst_abort", 32'(abort_a), 32'd0);
        en_a = 1'b1;
        tick();
        en_a = 1'b0;
        tick();
        chk("r_restart_gnt", 32'(gnt_a), 32'd1);
        chk("r_restart_key", 32'(ckey_a), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/crack_scheduler.md
Name: crack_scheduler

Overview:
- Sequences a pool of NUM_CORES ARC4 single-key crack cores across the 24-bit key space.
- Grants one candidate key per cycle to requesting cores in round-robin order and tracks the key each core holds.
- Stops the search on the first reported match and returns the matching key with the same rdy/en/key/key_valid contract as the crack engines, so the top-level 7-seg display logic can consume it unchanged.

Parameters:
NUM_CORES, 2, number of crack cores served; legal range 1-8.
KEY_FIRST, 24'h000000, first key dispatched.
KEY_LAST, 24'hFFFFFF, last key dispatched, inclusive; must be >= KEY_FIRST.

Ports:
clk  in  1  system clock.
rst_n  in  1  synchronous active-low reset.
en  in  1  start request; honoured only while rdy=1.
rdy  out  1  high when idle or done; low while searching.
key  out  24  matching key; valid when key_valid=1.
key_valid  out  1  search ended with a match.
core_req  in  NUM_CORES  core i is free and wants a key.
core_gnt  out  NUM_CORES  one-hot grant, one-cycle pulse.
core_key  out  24  key for the granted core; valid in the core_gnt cycle only.
core_done  in  NUM_CORES  core i finished its key (one-cycle pulse).
core_match  in  NUM_CORES  qualifies core_done: plaintext was all printable.
core_abort  out  1  one-cycle pulse; all cores drop their work and return to idle.

Behaviour:
- Reset state (rst_n=0 at a clk edge): state=IDLE, rdy=1, key=0, key_valid=0, core_gnt=0, core_abort=0, busy=0, next_key=KEY_FIRST, exhausted=0. Reset mid-search abandons the search without an abort pulse; cores are reset by the same rst_n.
- States: IDLE, RUN, ABORT, DONE.
- IDLE/DONE, rdy=1:
  - en=1 -> RUN next cycle.
  - On that edge: next_key=KEY_FIRST, exhausted=0, busy=0, key_valid=0, key=0, rdy=0.
  - DONE holds key/key_valid until the next en.
- RUN, dispatch:
  - Eligible set = core_req & ~busy.
  - If exhausted=0 and the eligible set is non-empty, grant exactly one core: round-robin, starting search at (last granted index+1) mod NUM_CORES; the pointer starts at 0 after reset and on every en.
  - Grant is registered: core_gnt[i]=1 and core_key=next_key for one cycle; busy[i] sets, assigned[i]=next_key.
  - Throughput is at most one grant per cycle.
- RUN, advance: on a grant, if next_key==KEY_LAST then exhausted=1 and next_key holds (no wrap to 0); else next_key+1.
- RUN, completion: core_done[i] with busy[i]=1 clears busy[i]. core_done from a non-busy core is ignored, as is core_req from a busy core.
- RUN, match:
  - If any busy core pulses core_done with core_match, the lowest index among them wins.
  - key=assigned[winner], key_valid=1, state -> ABORT; no further grants from that edge.
  - A match outranks a simultaneous grant: the grant issued in the same cycle still stands, but the following ABORT clears busy.
- ABORT: core_abort=1 for exactly one cycle, busy=0, then DONE.
- Exhausted without match: when exhausted=1 and busy==0 with no match in that cycle -> DONE, key_valid=0, key=0, no abort pulse.
- rdy rises on the DONE entry edge; key/key_valid are valid in the same cycle rdy first reads 1.
- Single key (KEY_FIRST==KEY_LAST): exactly one grant, then exhausted.
- core_key reads 0 whenever core_gnt==0.

Optional Feature:
- Macro: CRACK_PROGRESS_EN.
- With it: extra output keys_tried[23:0] counts core_done pulses from busy cores in the current search. It clears on en, saturates at 24'hFFFFFF, and holds in DONE.
- Without it: the port and counter are absent; all other behaviour is identical.

Test Plan:
- NUM_CORES=2, KEY_FIRST=0, KEY_LAST=5, both cores req=1 every free cycle, done 3 cycles after grant, no match -> grants alternate core0,core1 with keys 0..5 in order; DONE with key_valid=0, rdy=1, no core_abort.
- Same setup, core1 reports match on key 3 -> key=24'h000003, key_valid=1, one core_abort pulse, no grant after the match cycle, rdy=1 one cycle after abort.
- core0 and core1 both pulse done+match in the same cycle holding keys 8 and 9 -> key=24'h000008.
- KEY_FIRST=KEY_LAST=24'hFFFFFF -> exactly one grant with core_key=24'hFFFFFF, next_key does not wrap, DONE after its core_done.
- rst_n=0 for one cycle while 2 cores are busy -> next cycle rdy=1, key_valid=0, core_gnt=0, core_abort=0; a new en restarts from KEY_FIRST.
- en pulsed while in RUN is ignored; en in DONE clears key_valid and restarts; with CRACK_PROGRESS_EN, keys_tried=6 after the first scenario.
